// File: rtl/issue_stage.sv
// Single-entry issue register: holds one decoded instruction, resolves its source operands,
// and issues atomically to the ROB, the register status table and the reservation stations.
module issue_stage #(
    parameter int XLEN        = 64,
    parameter int REG_IDX_LEN = 5,
    parameter int ROB_IDX_LEN = 4,
    parameter int FU_LEN      = 3
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   flush_i,
    input  logic                   iq_valid_i,
    output logic                   iq_ready_o,
    input  logic [FU_LEN-1:0]      iq_fu_i,
    input  logic [REG_IDX_LEN-1:0] iq_rd_idx_i,
    input  logic [REG_IDX_LEN-1:0] iq_rs1_idx_i,
    input  logic [REG_IDX_LEN-1:0] iq_rs2_idx_i,
    input  logic                   iq_writes_rd_i,
    input  logic                   iq_uses_rs1_i,
    input  logic                   iq_uses_rs2_i,
    output logic                   regstat_valid_o,
    input  logic                   regstat_ready_i,
    output logic [REG_IDX_LEN-1:0] regstat_rd_idx_o,
    output logic [ROB_IDX_LEN-1:0] regstat_rob_idx_o,
    output logic [REG_IDX_LEN-1:0] regstat_rs1_idx_o,
    output logic [REG_IDX_LEN-1:0] regstat_rs2_idx_o,
    input  logic                   regstat_rs1_busy_i,
    input  logic                   regstat_rs2_busy_i,
    input  logic [ROB_IDX_LEN-1:0] regstat_rs1_rob_idx_i,
    input  logic [ROB_IDX_LEN-1:0] regstat_rs2_rob_idx_i,
    input  logic [XLEN-1:0]        rf_rs1_value_i,
    input  logic [XLEN-1:0]        rf_rs2_value_i,
    output logic [ROB_IDX_LEN-1:0] rob_rs1_idx_o,
    output logic [ROB_IDX_LEN-1:0] rob_rs2_idx_o,
    input  logic                   rob_rs1_ready_i,
    input  logic                   rob_rs2_ready_i,
    input  logic [XLEN-1:0]        rob_rs1_value_i,
    input  logic [XLEN-1:0]        rob_rs2_value_i,
    output logic                   rob_valid_o,
    input  logic                   rob_ready_i,
    input  logic [ROB_IDX_LEN-1:0] rob_tail_idx_i,
    output logic [REG_IDX_LEN-1:0] rob_rd_idx_o,
    output logic                   rs_valid_o,
    input  logic                   rs_ready_i,
    output logic [FU_LEN-1:0]      rs_fu_o,
    output logic                   rs_rs1_ready_o,
    output logic                   rs_rs2_ready_o,
    output logic [ROB_IDX_LEN-1:0] rs_rs1_rob_idx_o,
    output logic [ROB_IDX_LEN-1:0] rs_rs2_rob_idx_o,
    output logic [XLEN-1:0]        rs_rs1_value_o,
    output logic [XLEN-1:0]        rs_rs2_value_o,
    output logic [ROB_IDX_LEN-1:0] rs_dest_rob_idx_o
);

    typedef struct packed {
        logic                   ready;
        logic [ROB_IDX_LEN-1:0] tag;
        logic [XLEN-1:0]        value;
    } opnd_t;

    // Lookups see the status table before this instruction's own rd update,
    // so rs == rd correctly waits on the older producer.
    function automatic opnd_t resolve(
        input logic                   uses,
        input logic [REG_IDX_LEN-1:0] idx,
        input logic                   busy,
        input logic [ROB_IDX_LEN-1:0] tag,
        input logic                   rob_rdy,
        input logic [XLEN-1:0]        rf_val,
        input logic [XLEN-1:0]        rob_val
    );
        opnd_t o;
        o = '{ready: 1'b1, tag: '0, value: '0};
        if (!uses || idx == '0) begin
            o.ready = 1'b1;
        end else if (!busy) begin
            o.value = rf_val;
        end else if (rob_rdy) begin
            o.value = rob_val;
        end else begin
            o.ready = 1'b0;
            o.tag   = tag;
        end
        return o;
    endfunction

    logic                   valid_q, valid_d;
    logic [FU_LEN-1:0]      fu_q, fu_d;
    logic [REG_IDX_LEN-1:0] rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
    logic                   writes_rd_q, writes_rd_d;
    logic                   uses_rs1_q, uses_rs1_d, uses_rs2_q, uses_rs2_d;
    logic                   need_rd, fire, accept;
    opnd_t                  op1, op2;

    always_comb begin
        need_rd    = writes_rd_q && (rd_q != '0);
        fire       = valid_q && !flush_i && rob_ready_i && rs_ready_i
                     && (regstat_ready_i || !need_rd);
        iq_ready_o = !flush_i && (!valid_q || fire);
        accept     = iq_valid_i && iq_ready_o;

        valid_d     = valid_q;
        fu_d        = fu_q;
        rd_d        = rd_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        writes_rd_d = writes_rd_q;
        uses_rs1_d  = uses_rs1_q;
        uses_rs2_d  = uses_rs2_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d     = 1'b1;
            fu_d        = iq_fu_i;
            rd_d        = iq_rd_idx_i;
            rs1_d       = iq_rs1_idx_i;
            rs2_d       = iq_rs2_idx_i;
            writes_rd_d = iq_writes_rd_i;
            uses_rs1_d  = iq_uses_rs1_i;
            uses_rs2_d  = iq_uses_rs2_i;
        end else if (fire) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
        fu_q        <= fu_d;
        rd_q        <= rd_d;
        rs1_q       <= rs1_d;
        rs2_q       <= rs2_d;
        writes_rd_q <= writes_rd_d;
        uses_rs1_q  <= uses_rs1_d;
        uses_rs2_q  <= uses_rs2_d;
    end

    always_comb begin
        op1 = resolve(uses_rs1_q, rs1_q, regstat_rs1_busy_i, regstat_rs1_rob_idx_i,
                      rob_rs1_ready_i, rf_rs1_value_i, rob_rs1_value_i);
        op2 = resolve(uses_rs2_q, rs2_q, regstat_rs2_busy_i, regstat_rs2_rob_idx_i,
                      rob_rs2_ready_i, rf_rs2_value_i, rob_rs2_value_i);
    end

    assign rob_valid_o       = fire;
    assign rs_valid_o        = fire;
    assign regstat_valid_o   = fire && need_rd;
    assign regstat_rd_idx_o  = rd_q;
    assign regstat_rob_idx_o = rob_tail_idx_i;
    assign regstat_rs1_idx_o = rs1_q;
    assign regstat_rs2_idx_o = rs2_q;
    assign rob_rs1_idx_o     = regstat_rs1_rob_idx_i;
    assign rob_rs2_idx_o     = regstat_rs2_rob_idx_i;
    assign rob_rd_idx_o      = writes_rd_q ? rd_q : '0;
    assign rs_fu_o           = fu_q;
    assign rs_rs1_ready_o    = op1.ready;
    assign rs_rs1_rob_idx_o  = op1.tag;
    assign rs_rs1_value_o    = op1.value;
    assign rs_rs2_ready_o    = op2.ready;
    assign rs_rs2_rob_idx_o  = op2.tag;
    assign rs_rs2_value_o    = op2.value;
    assign rs_dest_rob_idx_o = rob_tail_idx_i;

endmodule

// File: tb/tb_issue_stage.sv
// Scoreboard bench for issue_stage: stimulus queues expected dispatches, a monitor checks them.
module tb_issue_stage;

    logic        clk, rst_n, flush;
    logic        iq_valid, iq_ready;
    logic [2:0]  iq_fu;
    logic [4:0]  iq_rd, iq_rs1, iq_rs2;
    logic        iq_wr, iq_u1, iq_u2;
    logic        regstat_valid, regstat_ready;
    logic [4:0]  regstat_rd_idx, regstat_rs1_idx, regstat_rs2_idx;
    logic [3:0]  regstat_rob_idx;
    logic        busy1, busy2;
    logic [3:0]  tag1, tag2;
    logic [63:0] rf1, rf2;
    logic [3:0]  rob_rs1_idx, rob_rs2_idx;
    logic        rob_rdy1, rob_rdy2;
    logic [63:0] rob_val1, rob_val2;
    logic        rob_valid, rob_ready;
    logic [3:0]  tail;
    logic [4:0]  rob_rd_idx;
    logic        rs_valid, rs_ready;
    logic [2:0]  rs_fu;
    logic        rs_r1, rs_r2;
    logic [3:0]  rs_t1, rs_t2, rs_dest;
    logic [63:0] rs_v1, rs_v2;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [2:0]  fu;
        logic        reg_v;
        logic [4:0]  rd;
        logic [3:0]  dest;
        logic [4:0]  rob_rd;
        logic        r1;
        logic [3:0]  t1;
        logic        t1c;
        logic [63:0] v1;
        logic        r2;
        logic [3:0]  t2;
        logic        t2c;
        logic [63:0] v2;
    } exp_t;

    exp_t q[$];

    issue_stage dut (
        .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush),
        .iq_valid_i(iq_valid), .iq_ready_o(iq_ready), .iq_fu_i(iq_fu),
        .iq_rd_idx_i(iq_rd), .iq_rs1_idx_i(iq_rs1), .iq_rs2_idx_i(iq_rs2),
        .iq_writes_rd_i(iq_wr), .iq_uses_rs1_i(iq_u1), .iq_uses_rs2_i(iq_u2),
        .regstat_valid_o(regstat_valid), .regstat_ready_i(regstat_ready),
        .regstat_rd_idx_o(regstat_rd_idx), .regstat_rob_idx_o(regstat_rob_idx),
        .regstat_rs1_idx_o(regstat_rs1_idx), .regstat_rs2_idx_o(regstat_rs2_idx),
        .regstat_rs1_busy_i(busy1), .regstat_rs2_busy_i(busy2),
        .regstat_rs1_rob_idx_i(tag1), .regstat_rs2_rob_idx_i(tag2),
        .rf_rs1_value_i(rf1), .rf_rs2_value_i(rf2),
        .rob_rs1_idx_o(rob_rs1_idx), .rob_rs2_idx_o(rob_rs2_idx),
        .rob_rs1_ready_i(rob_rdy1), .rob_rs2_ready_i(rob_rdy2),
        .rob_rs1_value_i(rob_val1), .rob_rs2_value_i(rob_val2),
        .rob_valid_o(rob_valid), .rob_ready_i(rob_ready), .rob_tail_idx_i(tail),
        .rob_rd_idx_o(rob_rd_idx),
        .rs_valid_o(rs_valid), .rs_ready_i(rs_ready), .rs_fu_o(rs_fu),
        .rs_rs1_ready_o(rs_r1), .rs_rs2_ready_o(rs_r2),
        .rs_rs1_rob_idx_o(rs_t1), .rs_rs2_rob_idx_o(rs_t2),
        .rs_rs1_value_o(rs_v1), .rs_rs2_value_o(rs_v2),
        .rs_dest_rob_idx_o(rs_dest)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [2:0] fu, input logic reg_v, input logic [4:0] rd,
                                input logic [3:0] dest, input logic [4:0] rob_rd,
                                input logic r1, input logic [3:0] t1, input logic t1c,
                                input logic [63:0] v1,
                                input logic r2, input logic [3:0] t2, input logic t2c,
                                input logic [63:0] v2);
        exp_t e;
        e.fu = fu; e.reg_v = reg_v; e.rd = rd; e.dest = dest; e.rob_rd = rob_rd;
        e.r1 = r1; e.t1 = t1; e.t1c = t1c; e.v1 = v1;
        e.r2 = r2; e.t2 = t2; e.t2c = t2c; e.v2 = v2;
        return e;
    endfunction

    // Monitor: every dispatch must match the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rs_valid === 1'b1) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_dispatch: got rs_valid=1 expected 0");
                end else begin
                    e = q.pop_front();
                    chk("rob_valid", rob_valid, 1);
                    chk("regstat_valid", regstat_valid, e.reg_v);
                    if (e.reg_v) chk("regstat_rd", regstat_rd_idx, e.rd);
                    chk("regstat_rob", regstat_rob_idx, e.dest);
                    chk("rs_dest", rs_dest, e.dest);
                    chk("rob_rd", rob_rd_idx, e.rob_rd);
                    chk("rs_fu", rs_fu, e.fu);
                    chk("rs1_ready", rs_r1, e.r1);
                    chk("rs1_value", rs_v1, e.v1);
                    if (e.t1c) chk("rs1_tag", rs_t1, e.t1);
                    chk("rs2_ready", rs_r2, e.r2);
                    chk("rs2_value", rs_v2, e.v2);
                    if (e.t2c) chk("rs2_tag", rs_t2, e.t2);
                end
            end
        end
    end

    task automatic drive_iq(input logic [2:0] fu, input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic wr, input logic u1, input logic u2);
        iq_valid = 1'b1; iq_fu = fu; iq_rd = rd; iq_rs1 = rs1; iq_rs2 = rs2;
        iq_wr = wr; iq_u1 = u1; iq_u2 = u2;
    endtask

    // Leaves the instruction latched (FULL), returning #1 after the accepting edge.
    task automatic accept(input logic [2:0] fu, input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic wr, input logic u1, input logic u2);
        @(posedge clk);
        #1;
        drive_iq(fu, rd, rs1, rs2, wr, u1, u2);
        @(negedge clk);
        chk("iq_ready_accept", iq_ready, 1);
        @(posedge clk);
        #1;
        iq_valid = 1'b0;
    endtask

    task automatic expect_dispatch(input exp_t e);
        q.push_back(e);
        @(posedge clk);
        #1;
        chk("dispatched", q.size(), 0);
    endtask

    task automatic set_ops(input logic b1, input logic [3:0] t1, input logic rr1,
                           input logic [63:0] f1, input logic [63:0] rv1,
                           input logic b2, input logic [3:0] t2, input logic rr2,
                           input logic [63:0] f2, input logic [63:0] rv2);
        busy1 = b1; tag1 = t1; rob_rdy1 = rr1; rf1 = f1; rob_val1 = rv1;
        busy2 = b2; tag2 = t2; rob_rdy2 = rr2; rf2 = f2; rob_val2 = rv2;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0;
        iq_valid = 1'b0; iq_fu = '0; iq_rd = '0; iq_rs1 = '0; iq_rs2 = '0;
        iq_wr = 1'b0; iq_u1 = 1'b0; iq_u2 = 1'b0;
        regstat_ready = 1'b1; rob_ready = 1'b1; rs_ready = 1'b1; tail = '0;
        set_ops(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset, then idle
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rob_valid", rob_valid, 0);
        chk("rst_rs_valid", rs_valid, 0);
        chk("rst_regstat_valid", regstat_valid, 0);
        chk("rst_iq_ready", iq_ready, 1);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("idle_rs_valid", rs_valid, 0);
        chk("idle_iq_ready", iq_ready, 1);

        // add x5 <- x1, x2 from the register file
        accept(3'd1, 5'd5, 5'd1, 5'd2, 1, 1, 1);
        set_ops(0, 0, 0, 64'h11, 64'hEE, 0, 0, 0, 64'h22, 64'hEE);
        tail = 4'd3;
        expect_dispatch(mk(3'd1, 1, 5'd5, 4'd3, 5'd5, 1, 4'd0, 0, 64'h11, 1, 4'd0, 0, 64'h22));

        // rs1 waits on tag 6; rs2 is x0 so ignores its busy bit
        accept(3'd4, 5'd7, 5'd3, 5'd0, 1, 1, 1);
        set_ops(1, 4'd6, 0, 64'h55, 64'h99, 1, 4'd9, 0, 64'h77, 64'h66);
        tail = 4'd5;
        expect_dispatch(mk(3'd4, 1, 5'd7, 4'd5, 5'd7, 0, 4'd6, 1, 64'h0, 1, 4'd0, 1, 64'h0));

        // rs1 producer already complete in the ROB
        accept(3'd4, 5'd7, 5'd3, 5'd0, 1, 1, 1);
        set_ops(1, 4'd6, 1, 64'h55, 64'hAB, 1, 4'd9, 0, 64'h77, 64'h66);
        tail = 4'd6;
        expect_dispatch(mk(3'd4, 1, 5'd7, 4'd6, 5'd7, 1, 4'd0, 0, 64'hAB, 1, 4'd0, 1, 64'h0));

        // rd = x0: fires despite regstat not ready, no ownership write; rs1 unused
        accept(3'd0, 5'd0, 5'd4, 5'd8, 1, 0, 1);
        set_ops(0, 0, 0, 64'h44, 64'h0, 0, 0, 0, 64'h88, 64'h0);
        regstat_ready = 1'b0;
        tail = 4'd2;
        expect_dispatch(mk(3'd0, 0, 5'd0, 4'd2, 5'd0, 1, 4'd0, 1, 64'h0, 1, 4'd0, 0, 64'h88));
        regstat_ready = 1'b1;

        // ROB full for 3 cycles with a waiting successor
        accept(3'd2, 5'd9, 5'd1, 5'd2, 1, 1, 1);
        set_ops(0, 0, 0, 64'h31, 64'h0, 0, 0, 0, 64'h32, 64'h0);
        tail = 4'd7;
        rob_ready = 1'b0;
        drive_iq(3'd5, 5'd10, 5'd3, 5'd4, 1, 1, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_iq_ready", iq_ready, 0);
            chk("stall_rob_valid", rob_valid, 0);
            chk("stall_rd_stable", regstat_rd_idx, 9);
            chk("stall_fu_stable", rs_fu, 2);
        end
        @(posedge clk);
        #1;
        rob_ready = 1'b1;
        q.push_back(mk(3'd2, 1, 5'd9, 4'd7, 5'd9, 1, 4'd0, 0, 64'h31, 1, 4'd0, 0, 64'h32));
        @(negedge clk);
        chk("flowthrough_iq_ready", iq_ready, 1);
        @(posedge clk);
        #1;
        chk("dispatched", q.size(), 0);
        iq_valid = 1'b0;
        tail = 4'd8;
        expect_dispatch(mk(3'd5, 1, 5'd10, 4'd8, 5'd10, 1, 4'd0, 0, 64'h31, 1, 4'd0, 0, 64'h32));

        // Flush while stalled, with a new instruction offered
        accept(3'd1, 5'd12, 5'd5, 5'd6, 1, 1, 1);
        rob_ready = 1'b0;
        flush = 1'b1;
        drive_iq(3'd3, 5'd13, 5'd1, 5'd1, 1, 1, 1);
        @(negedge clk);
        chk("flush_rs_valid", rs_valid, 0);
        chk("flush_iq_ready", iq_ready, 0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        iq_valid = 1'b0;
        rob_ready = 1'b1;
        @(negedge clk);
        chk("post_flush_rs_valid", rs_valid, 0);
        chk("post_flush_regstat_valid", regstat_valid, 0);
        chk("post_flush_iq_ready", iq_ready, 1);

        repeat (3) @(posedge clk);
        chk("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/issue_stage.md
Name: issue_stage

Overview:
- Single-entry issue register between the instruction queue and the back end.
- Latches one decoded instruction and resolves its source operands from the register status table, the register file and the ROB.
- In one atomic cycle it allocates the ROB tail, records rd ownership in the register status table, and dispatches to the reservation stations.

Parameters:
XLEN, 64, operand data width
REG_IDX_LEN, 5, architectural register index width
ROB_IDX_LEN, 4, ROB entry index width
FU_LEN, 3, functional-unit selector width

Ports:
clk_i  in  1  clock
rst_n_i  in  1  synchronous active-low reset
flush_i  in  1  synchronous pipeline flush
iq_valid_i  in  1  instruction queue has an instruction
iq_ready_o  out  1  issue register can accept
iq_fu_i  in  FU_LEN  target functional unit
iq_rd_idx_i / iq_rs1_idx_i / iq_rs2_idx_i  in  REG_IDX_LEN  register indices
iq_writes_rd_i / iq_uses_rs1_i / iq_uses_rs2_i  in  1  operand usage flags
regstat_valid_o  out  1  write rd ownership into the register status table
regstat_ready_i  in  1  register status table ready
regstat_rd_idx_o  out  REG_IDX_LEN  rd index to record
regstat_rob_idx_o  out  ROB_IDX_LEN  ROB tail being allocated
regstat_rs1_idx_o / regstat_rs2_idx_o  out  REG_IDX_LEN  source lookup indices
regstat_rs1_busy_i / regstat_rs2_busy_i  in  1  source has an in-flight producer
regstat_rs1_rob_idx_i / regstat_rs2_rob_idx_i  in  ROB_IDX_LEN  producer ROB entry
rf_rs1_value_i / rf_rs2_value_i  in  XLEN  register file read data (same indices)
rob_rs1_idx_o / rob_rs2_idx_o  out  ROB_IDX_LEN  ROB lookup indices (= producer tags)
rob_rs1_ready_i / rob_rs2_ready_i  in  1  producer result already in ROB
rob_rs1_value_i / rob_rs2_value_i  in  XLEN  ROB result
rob_valid_o  out  1  allocate ROB tail
rob_ready_i  in  1  ROB not full
rob_tail_idx_i  in  ROB_IDX_LEN  current ROB tail
rob_rd_idx_o  out  REG_IDX_LEN  destination written into the ROB entry
rs_valid_o  out  1  dispatch to reservation station
rs_ready_i  in  1  selected reservation station has a free entry
rs_fu_o  out  FU_LEN  target unit
rs_rs1_ready_o / rs_rs2_ready_o  out  1  operand value valid
rs_rs1_rob_idx_o / rs_rs2_rob_idx_o  out  ROB_IDX_LEN  wait tag when not ready
rs_rs1_value_o / rs_rs2_value_o  out  XLEN  operand value
rs_dest_rob_idx_o  out  ROB_IDX_LEN  destination ROB entry

Behaviour:
- State: valid_q plus latched instruction fields. EMPTY (valid_q=0) / FULL (valid_q=1).
- Reset (rst_n_i=0 at posedge): valid_q=0. All *_valid_o are 0 while empty. iq_ready_o=1 after reset.
- fire = valid_q & rob_ready_i & rs_ready_i & (regstat_ready_i | ~need_rd).
  - need_rd = writes_rd & (rd != 0).
- rob_valid_o = rs_valid_o = fire. regstat_valid_o = fire & need_rd.
  - These valids intentionally depend on the readies: all-or-nothing issue, no partial allocation.
- iq_ready_o = ~valid_q | fire (flow-through). Accept = iq_valid_i & iq_ready_o: latch fields, valid_q=1 next cycle.
- Back-to-back: 1 instruction/cycle sustained when readies are held high; latency from accept to dispatch is 1 cycle.
- Operand resolution is combinational from latched indices, evaluated per source in priority order:
  1. Not used, or idx == 0: ready=1, value=0, tag=0.
  2. Not busy: ready=1, value=rf value.
  3. Busy and rob_*_ready_i: ready=1, value=ROB value.
  4. Otherwise: ready=0, value=0, tag=regstat rob idx.
- rob_*_idx_o = regstat_*_rob_idx_i.
- Same-entry hazard: rs1/rs2 lookup uses table state before this instruction's own rd update. An instruction with rs1 == rd reads the older producer.
- regstat_rob_idx_o = rs_dest_rob_idx_o = rob_tail_idx_i. rob_rd_idx_o = rd (or 0 if ~writes_rd).
- Stall: FULL & ~fire holds all latched fields stable. Operands are re-resolved every cycle, so readiness may improve while stalled.
- flush_i: valid_q=0 next cycle. All *_valid_o forced 0 and iq_ready_o forced 0 in the flush cycle. Flush has priority over accept and fire. Reset has priority over flush.

Test Plan:
- Reset then idle: rst_n_i=0 for 2 cycles → all *_valid_o=0, iq_ready_o=1; release → still 0 valids.
- Accept add x5←x1,x2 with busy=0, rf=0x11/0x22, tail=3, all ready → next cycle rob/rs/regstat_valid_o=1, values 0x11/0x22 ready, regstat rd=5 rob=3.
- rs1 busy tag 6, rob_rs1_ready_i=0 → rs_rs1_ready_o=0, rs_rs1_rob_idx_o=6; repeat with rob_rs1_ready_i=1, value 0xAB → ready=1, value=0xAB.
- rd=x0, writes_rd=1, regstat_ready_i=0 → fire still occurs, regstat_valid_o=0.
- rob_ready_i=0 for 3 cycles with iq_valid_i=1 → no valids, iq_ready_o=0, fields stable; rob_ready_i=1 → fire and new accept same cycle.
- FULL and stalled, flush_i=1 with iq_valid_i=1 → no fire, no accept, valid_q=0 next cycle, iq_ready_o=1.
